prog_sequencer: RTL
===================

Name: prog_sequencer

Overview:
Run controller for the fetch/execute core. It accepts a start request naming one of three programs and holds the core in `core_init`. It then loads that program's start address into the program counter. It lets the core run until `halt`, then freezes the core, reports completion and reports the run's cycle count. The block sits between the testbench/top-level and the IF/PC stage, and replaces ad-hoc program selection inside the PC.

Parameters:
- PC_W, 10, program counter width.
- CNT_W, 16, width of the cycle counter.
- INIT_CYCLES, 2, cycles `core_init` is held high before the load (≥1).
- PROG1_PC, 0, start address of program 1.
- PROG2_PC, 256, start address of program 2.
- PROG3_PC, 512, start address of program 3.
- WDOG_LIMIT, 4096, RUN-cycle limit when watchdog is compiled in.

Ports:
- CLK  in  1  system clock, rising edge.
- init  in  1  reset, asynchronous, active-high.
- start  in  1  run request, sampled each edge.
- prog_sel  in  2  program to run (1..3), sampled with start.
- halt  in  1  core halt flag.
- core_init  out  1  holds core in init/freeze.
- pc_load  out  1  one-cycle load strobe to PC.
- start_pc  out  PC_W  address to load; valid while pc_load=1.
- prog_id  out  2  program of current/last run.
- busy  out  1  high in INIT, LOAD, RUN.
- done  out  1  high in DONE.
- err  out  1  one-cycle pulse: start with invalid prog_sel.
- cycle_count  out  CNT_W  RUN cycles of current/last run.
- timeout  out  1  watchdog abort flag (0 when feature absent).

Behaviour:
- Reset values (async, immediate): state=IDLE, core_init=1, pc_load=0, start_pc=0, prog_id=0, busy=0, done=0, err=0, cycle_count=0, timeout=0.
- States are IDLE, INIT, LOAD, RUN, DONE. All outputs are registered.
- IDLE/DONE: core_init=1.
  - start=1 with prog_sel∈{1,2,3} → INIT next edge. In the same edge: latch prog_id, clear cycle_count/timeout, clear done, load init counter with INIT_CYCLES-1.
  - start=1 with prog_sel=0 → err=1 for one cycle; state, done and prog_id are unchanged.
- INIT: core_init=1, busy=1. The counter decrements; at 0 → LOAD. `core_init` is high for exactly INIT_CYCLES cycles in INIT.
- LOAD: core_init=0, pc_load=1 for exactly one cycle, start_pc = PROGn_PC for the latched prog_id. Next state RUN.
- RUN: core_init=0, busy=1. cycle_count increments every RUN cycle and saturates at all-ones (no wrap).
  - halt sampled high → DONE next edge; cycle_count freezes (the halt cycle is counted).
- DONE: done=1, busy=0, core_init=1. done, prog_id and cycle_count hold until the next accepted start.
- Ignored inputs:
  - start in INIT/LOAD/RUN is ignored (no queueing, no err).
  - halt in IDLE/INIT/LOAD/DONE is ignored.
- start and halt on the same edge in RUN: halt wins → DONE; start is dropped.
- start held high continuously: one run per entry into DONE. A new run begins on the first edge in DONE with start=1, i.e. back-to-back runs with one DONE cycle between.
- Reset asserted mid-run: immediate return to reset values; the core is re-held by core_init=1.

Optional Feature:
- Macro PROG_SEQ_WATCHDOG_EN.
- Defined: in RUN, if cycle_count reaches WDOG_LIMIT without halt → DONE next edge with timeout=1. timeout holds until the next accepted start. halt on the limit cycle takes precedence: timeout=0.
- Undefined: no limit check; timeout tied to 0; RUN lasts until halt.

Decomposition:
- Package prog_seq_pkg holds:
  - state enum typedef (IDLE, INIT, LOAD, RUN, DONE);
  - 2-bit prog_id typedef;
  - default start-address localparams;
  - a function mapping prog_id to start address.
- One sub-module, sat_counter (CNT_W, clear, enable, saturating), is used for cycle_count. The init countdown stays inline.

Test Plan:
- Reset then start=1, prog_sel=2:
  - core_init stays high 2 cycles;
  - pc_load=1 with start_pc=256 for one cycle;
  - busy=1 until halt.
- Run prog 1, assert halt on the 37th RUN cycle → done=1 next edge, cycle_count=37, prog_id=1, core_init=1.
- start with prog_sel=0 in IDLE → err pulses 1 cycle, state stays IDLE, done=0. The same request in DONE leaves done=1.
- start pulsed during RUN and LOAD → no effect. start+halt on the same RUN edge → DONE, no new INIT.
- Assert init during RUN (cycle 10) asynchronously → all outputs return to reset values before the next edge. A subsequent start with prog_sel=3 loads 512.
- With PROG_SEQ_WATCHDOG_EN and WDOG_LIMIT=20, never halt → DONE with timeout=1, cycle_count=20. With halt on cycle 20 → timeout=0.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg
// Shared types and helpers for the program run controller.
//   state_t         : controller states IDLE, INIT, LOAD, RUN, DONE
//   prog_id_t       : 2-bit program identifier (0 is not a valid program)
//   DEF_PROGn_PC    : default start addresses of the three programs
//   prog_start_addr : maps a program id onto its start address
package prog_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      LOAD,
      RUN,
      DONE
   } state_t;

   typedef logic [1:0] prog_id_t;

   localparam int unsigned DEF_PROG1_PC = 0;
   localparam int unsigned DEF_PROG2_PC = 256;
   localparam int unsigned DEF_PROG3_PC = 512;

   // The caller supplies the three addresses so per-instance overrides are
   // honoured; id 0 never reaches LOAD, so its result is only a safe default.
   function automatic int unsigned prog_start_addr(
      input prog_id_t    id,
      input int unsigned p1,
      input int unsigned p2,
      input int unsigned p3
   );
      case (id)
         2'd1:    return p1;
         2'd2:    return p2;
         2'd3:    return p3;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset, clears the count
//   clear  : synchronous clear, has priority over enable
//   enable : count up by one on this edge
//   count  : current value
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   // Holding at all-ones keeps an overlong run from reporting a small count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer
// Run controller for the fetch/execute core. A start request selects one of
// three programs; the core is held in init, its PC is loaded with the
// program's start address, the core runs until halt, and is then frozen
// while completion and the run's cycle count are reported.
//
// Optional build macro PROG_SEQ_WATCHDOG_EN: aborts a run that reaches
// WDOG_LIMIT RUN cycles without halt and flags it on timeout. The
// WDOG_LIMIT parameter exists only in that build; otherwise timeout is 0.
//
// Ports:
//   CLK         in  system clock, rising edge
//   init        in  asynchronous active-high reset
//   start       in  run request, sampled each edge
//   prog_sel    in  program to run (1..3), sampled with start
//   halt        in  core halt flag
//   core_init   out holds the core in init/freeze
//   pc_load     out one-cycle load strobe to the PC
//   start_pc    out address to load, valid while pc_load=1
//   prog_id     out program of the current/last run
//   busy        out high in INIT, LOAD, RUN
//   done        out high in DONE
//   err         out one-cycle pulse for a start with prog_sel=0
//   cycle_count out RUN cycles of the current/last run
//   timeout     out watchdog abort flag
module prog_sequencer
   import prog_seq_pkg::*;
#(
   parameter int          PC_W        = 10,
   parameter int          CNT_W       = 16,
   parameter int          INIT_CYCLES = 2,
   parameter int unsigned PROG1_PC    = DEF_PROG1_PC,
   parameter int unsigned PROG2_PC    = DEF_PROG2_PC,
   parameter int unsigned PROG3_PC    = DEF_PROG3_PC
`ifdef PROG_SEQ_WATCHDOG_EN
   ,
   parameter int unsigned WDOG_LIMIT  = 4096
`endif
) (
   input  logic             CLK,
   input  logic             init,
   input  logic             start,
   input  logic [1:0]       prog_sel,
   input  logic             halt,
   output logic             core_init,
   output logic             pc_load,
   output logic [PC_W-1:0]  start_pc,
   output prog_id_t         prog_id,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] cycle_count,
   output logic             timeout
);

   // Wide enough to hold INIT_CYCLES-1, never narrower than one bit.
   localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

   state_t            state;
   logic [INIT_W-1:0] init_cnt;
   logic              accept;
   logic              run_en;
   logic              wdog_hit;

   // A start is only honoured from IDLE or DONE and only for a real program.
   assign accept = (state == IDLE || state == DONE) && start && (prog_sel != 2'd0);
   assign run_en = (state == RUN);

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_cycle_cnt (
      .clk    (CLK),
      .rst    (init),
      .clear  (accept),
      .enable (run_en),
      .count  (cycle_count)
   );

`ifdef PROG_SEQ_WATCHDOG_EN
   // The limit edge is the one on which the counter steps to WDOG_LIMIT.
   assign wdog_hit = run_en && (cycle_count == CNT_W'(WDOG_LIMIT - 1));

   // A halt on the limit cycle is a normal completion, not an abort.
   always_ff @(posedge CLK or posedge init) begin
      if (init) begin
         timeout <= 1'b0;
      end else if (accept) begin
         timeout <= 1'b0;
      end else if (wdog_hit && !halt) begin
         timeout <= 1'b1;
      end
   end
`else
   assign wdog_hit = 1'b0;
   assign timeout  = 1'b0;
`endif

   // Controller state and all registered outputs. Transitions update the
   // outputs for the state being entered so they line up with that state.
   always_ff @(posedge CLK or posedge init) begin
      if (init) begin
         state     <= IDLE;
         init_cnt  <= '0;
         core_init <= 1'b1;
         pc_load   <= 1'b0;
         start_pc  <= '0;
         prog_id   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         err     <= 1'b0;
         pc_load <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  if (prog_sel != 2'd0) begin
                     state    <= INIT;
                     prog_id  <= prog_sel;
                     done     <= 1'b0;
                     busy     <= 1'b1;
                     init_cnt <= INIT_W'(INIT_CYCLES - 1);
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            INIT: begin
               if (init_cnt == '0) begin
                  state     <= LOAD;
                  core_init <= 1'b0;
                  pc_load   <= 1'b1;
                  start_pc  <= PC_W'(prog_start_addr(prog_id, PROG1_PC, PROG2_PC, PROG3_PC));
               end else begin
                  init_cnt <= init_cnt - INIT_W'(1);
               end
            end
            LOAD: begin
               state <= RUN;
            end
            RUN: begin
               if (halt || wdog_hit) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  core_init <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
